// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM-stage load/store port
// and a display scan engine that streams a frame-buffer window to the display.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned SCAN_BASE = 0,
   parameter int unsigned SCAN_LEN  = 64,
   parameter int unsigned MAX_WAIT  = 7
) (
   input  logic              in_CLK,
   input  logic              in_RST,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              scan_en,
   output logic [DATA_W-1:0] scan_data,
   output logic [ADDR_W-1:0] scan_addr,
   output logic              scan_valid,
   output logic              frame_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned       WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(SCAN_BASE);
   localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(SCAN_BASE + SCAN_LEN - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   typedef enum logic {S_IDLE, S_RUN} scan_state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_SCAN} tag_kind_t;

   typedef struct packed {
      tag_kind_t         kind;
      logic [ADDR_W-1:0] addr;
      logic              last;
   } ret_tag_t;

   scan_state_t       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   ret_tag_t          tag_q, tag_d;
   logic [DATA_W-1:0] cpu_hold_q, scan_hold_q;

   logic cpu_req_ok, force_scan, grant_cpu, grant_scan, ptr_at_last;

   // State, pointer, starvation counter and return tag
   always_ff @(posedge in_CLK or negedge in_RST) begin
      if (!in_RST) begin
         state_q <= S_IDLE;
         ptr_q   <= BASE_A;
         wait_q  <= '0;
         tag_q   <= '{kind: TAG_NONE, addr: '0, last: 1'b0};
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         wait_q  <= wait_d;
         tag_q   <= tag_d;
      end
   end

   // Last returned words, held between valid pulses
   always_ff @(posedge in_CLK or negedge in_RST) begin
      if (!in_RST) begin
         cpu_hold_q  <= '0;
         scan_hold_q <= '0;
      end else begin
         if (cpu_rvalid)  cpu_hold_q  <= mem_rdata;
         if (scan_valid)  scan_hold_q <= mem_rdata;
      end
   end

   // Arbitration, scan FSM next state and memory drive
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      wait_d      = wait_q;
      tag_d       = '{kind: TAG_NONE, addr: tag_q.addr, last: 1'b0};
      grant_cpu   = 1'b0;
      grant_scan  = 1'b0;
      mem_addr    = ptr_q;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      ptr_at_last = (ptr_q == LAST_A);

      // Requests are ignored while reset is held so every output reads zero
      cpu_req_ok  = cpu_req & in_RST;
      force_scan  = (state_q == S_RUN) && (wait_q == WAIT_MAX);

      if (cpu_req_ok && !force_scan)
         grant_cpu = 1'b1;
      else if (state_q == S_RUN && in_RST)
         grant_scan = 1'b1;

      cpu_stall = cpu_req_ok && !grant_cpu;

      case (state_q)
         S_IDLE: begin
            wait_d = '0;
            if (scan_en) begin
               state_d = S_RUN;
               ptr_d   = BASE_A;
            end
         end
         S_RUN: begin
            if (grant_scan) begin
               wait_d = '0;
               ptr_d  = ptr_at_last ? BASE_A : ptr_q + ADDR_W'(1);
               if (ptr_at_last && !scan_en)
                  state_d = S_IDLE;
            end else if (wait_q != WAIT_MAX) begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (grant_cpu) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_wdata = cpu_wdata;
         if (!cpu_we)
            tag_d.kind = TAG_CPU;
      end else if (grant_scan) begin
         tag_d = '{kind: TAG_SCAN, addr: ptr_q, last: ptr_at_last};
      end
   end

   // Return path: memory read data is valid the cycle after the grant
   assign cpu_rvalid = (tag_q.kind == TAG_CPU);
   assign scan_valid = (tag_q.kind == TAG_SCAN);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold_q;
   assign scan_data  = scan_valid ? mem_rdata : scan_hold_q;
   assign scan_addr  = tag_q.addr;
   assign frame_done = scan_valid && tag_q.last;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a synchronous memory model plus
// scoreboard queues of expected scan words and load returns.
module tb_dmem_port_arbiter;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;
   localparam int unsigned SL = 64;

   logic          in_CLK = 1'b0;
   logic          in_RST = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0, scan_en = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_stall, cpu_rvalid, scan_valid, frame_done, mem_we;
   logic [DW-1:0] cpu_rdata, scan_data, mem_wdata, mem_rdata;
   logic [AW-1:0] scan_addr, mem_addr;

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SCAN_BASE(0), .SCAN_LEN(SL), .MAX_WAIT(7)) dut (
      .in_CLK(in_CLK), .in_RST(in_RST),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .scan_en(scan_en), .scan_data(scan_data), .scan_addr(scan_addr),
      .scan_valid(scan_valid), .frame_done(frame_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 in_CLK = ~in_CLK;

   // Memory model: unwritten word i reads 0x1000+i
   logic [DW-1:0] mem [0:4095];
   bit   [4095:0] mem_wr;
   always @(posedge in_CLK) begin
      if (mem_we) begin
         mem[mem_addr]    <= mem_wdata;
         mem_wr[mem_addr] <= 1'b1;
      end
      mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : DW'(32'h1000 + 32'(mem_addr));
   end

   // Bench-side view of memory contents after the stores it issues
   logic [DW-1:0] ref_mem [0:4095];
   bit   [4095:0] ref_wr;
   function automatic logic [DW-1:0] exp_word(input int a);
      return ref_wr[a] ? ref_mem[a] : DW'(32'h1000 + a);
   endfunction

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } scan_exp_t;

   scan_exp_t     scan_q [$];
   logic [DW-1:0] cpu_q [$];
   scan_exp_t     mon_e;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge in_CLK);
   endtask

   task automatic push_frame();
      for (int i = 0; i < int'(SL); i++)
         scan_q.push_back('{addr: AW'(i), data: exp_word(i), last: (i == int'(SL) - 1)});
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((scan_q.size() != 0 || cpu_q.size() != 0) && n < budget) begin
         cyc();
         n++;
      end
      chk("drain_scan", 64'(scan_q.size()), 64'(0));
      chk("drain_cpu", 64'(cpu_q.size()), 64'(0));
      repeat (4) cyc();
   endtask

   // Output monitor: every return pulse must match the head of its queue
   always @(negedge in_CLK) begin
      if (in_RST) begin
         if (scan_valid) begin
            if (scan_q.size() == 0) begin
               chk("scan_unexpected", 64'(scan_addr), 64'hFFFF);
            end else begin
               mon_e = scan_q.pop_front();
               chk("scan_addr", 64'(scan_addr), 64'(mon_e.addr));
               chk("scan_data", 64'(scan_data), 64'(mon_e.data));
               chk("frame_done", 64'(frame_done), 64'(mon_e.last));
            end
         end else if (frame_done) begin
            chk("frame_done_orphan", 64'(frame_done), 64'(0));
         end
         if (cpu_rvalid) begin
            if (cpu_q.size() == 0)
               chk("cpu_unexpected", 64'(cpu_rdata), 64'hFFFF_FFFF_FFFF);
            else
               chk("cpu_rdata", 64'(cpu_rdata), 64'(cpu_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int la;
      bit exp_stall;
      int n;

      // Reset state
      repeat (2) cyc();
      chk("rst_scan_valid", 64'(scan_valid), 64'(0));
      chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_frame_done", 64'(frame_done), 64'(0));
      chk("rst_scan_data", 64'(scan_data), 64'(0));

      // Free-running scan, then scan_en dropped mid-way through the second frame
      push_frame();
      push_frame();
      scan_en = 1'b1;
      in_RST  = 1'b1;
      cyc(); #1;
      chk("t1_first_valid_early", 64'(scan_valid), 64'(0));
      chk("t1_first_addr", 64'(mem_addr), 64'(0));
      cyc(); #1;
      chk("t1_first_valid", 64'(scan_valid), 64'(1));
      n = 0;
      while (scan_q.size() > SL - 9 && n < 300) begin
         chk("t1_no_stall", 64'(cpu_stall), 64'(0));
         cyc();
         n++;
      end
      scan_en = 1'b0;
      drain(200);

      // Store then load with the scan idle
      cyc();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(5); cpu_wdata = 32'hDEADBEEF;
      ref_mem[5] = 32'hDEADBEEF; ref_wr[5] = 1'b1;
      #1;
      chk("t2_store_we", 64'(mem_we), 64'(1));
      chk("t2_store_addr", 64'(mem_addr), 64'(5));
      chk("t2_store_data", 64'(mem_wdata), 64'hDEADBEEF);
      chk("t2_store_stall", 64'(cpu_stall), 64'(0));
      cyc();
      cpu_we = 1'b0;
      cpu_q.push_back(exp_word(5));
      #1;
      chk("t2_load_we", 64'(mem_we), 64'(0));
      chk("t2_load_stall", 64'(cpu_stall), 64'(0));
      cyc();
      cpu_req = 1'b0;
      chk("t2_rvalid_latency", 64'(cpu_rvalid), 64'(1));
      cyc();
      chk("t2_rvalid_pulse", 64'(cpu_rvalid), 64'(0));
      chk("t2_rdata_hold", 64'(cpu_rdata), 64'hDEADBEEF);

      // Back-to-back loads against a running scan: forced grants on cycles 8 and 16
      push_frame();
      la = 200;
      for (int k = 0; k < 20; k++) begin
         cyc();
         scan_en  = 1'b1;
         cpu_req  = 1'b1;
         cpu_we   = 1'b0;
         cpu_addr = AW'(la);
         exp_stall = (k == 8 || k == 16);
         #1;
         chk($sformatf("t3_stall_c%0d", k), 64'(cpu_stall), 64'(exp_stall));
         if (!exp_stall) begin
            cpu_q.push_back(exp_word(la));
            la++;
         end
      end
      cyc();
      cpu_req = 1'b0;
      scan_en = 1'b0;
      drain(200);

      // Reset while a load is in flight
      cyc();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(7);
      @(posedge in_CLK);
      #2;
      in_RST = 1'b0;
      #1;
      chk("t5_rvalid", 64'(cpu_rvalid), 64'(0));
      chk("t5_stall", 64'(cpu_stall), 64'(0));
      chk("t5_mem_we", 64'(mem_we), 64'(0));
      chk("t5_mem_addr", 64'(mem_addr), 64'(0));
      chk("t5_cpu_rdata", 64'(cpu_rdata), 64'(0));
      chk("t5_scan_addr", 64'(scan_addr), 64'(0));
      cyc();
      chk("t5_rvalid_held", 64'(cpu_rvalid), 64'(0));
      cpu_req = 1'b0;
      scan_en = 1'b1;
      push_frame();
      in_RST  = 1'b1;
      cyc(); #1;
      chk("t5_restart_addr", 64'(mem_addr), 64'(0));
      chk("t5_restart_valid", 64'(scan_valid), 64'(0));
      scan_en = 1'b0;
      drain(200);

      // Forced scan grant coincides with a store
      push_frame();
      la = 400;
      for (int k = 0; k < 8; k++) begin
         cyc();
         scan_en  = 1'b1;
         cpu_req  = 1'b1;
         cpu_we   = 1'b0;
         cpu_addr = AW'(la);
         cpu_q.push_back(exp_word(la));
         la++;
         #1;
         chk($sformatf("t6_load_stall_c%0d", k), 64'(cpu_stall), 64'(0));
      end
      cyc();
      cpu_we = 1'b1; cpu_addr = AW'(300); cpu_wdata = 32'hCAFEF00D;
      #1;
      chk("t6_force_stall", 64'(cpu_stall), 64'(1));
      chk("t6_force_we", 64'(mem_we), 64'(0));
      chk("t6_force_addr", 64'(mem_addr), 64'(0));
      cyc(); #1;
      chk("t6_store_stall", 64'(cpu_stall), 64'(0));
      chk("t6_store_we", 64'(mem_we), 64'(1));
      chk("t6_store_addr", 64'(mem_addr), 64'(300));
      chk("t6_store_data", 64'(mem_wdata), 64'hCAFEF00D);
      ref_mem[300] = 32'hCAFEF00D; ref_wr[300] = 1'b1;
      cyc();
      cpu_we  = 1'b0;
      scan_en = 1'b0;
      cpu_q.push_back(exp_word(300));
      #1;
      chk("t6_readback_stall", 64'(cpu_stall), 64'(0));
      cyc();
      cpu_req = 1'b0;
      drain(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the MEM-stage load/store port and a built-in display scan engine.
- The scan engine continuously walks a frame buffer window and streams the words to the display sink.
- The CPU has priority. A wait counter bounds display starvation by stalling the pipeline for one cycle when the limit is reached.
- Sits between the EX/MEM pipeline register, the data memory and the display block.

Parameters:
- ADDR_W, 12, word address width into data memory.
- DATA_W, 32, data word width.
- SCAN_BASE, 0, first word address of the display window.
- SCAN_LEN, 64, number of words in the display window (>=2, SCAN_BASE+SCAN_LEN <= 2^ADDR_W).
- MAX_WAIT, 7, consecutive denied scan cycles before a forced scan grant (>=1).

Ports:
- in_CLK  in  1  clock; all state updates on the rising edge.
- in_RST  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM-stage access request; held stable while cpu_stall=1.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_stall  out  1  combinational; request not granted this cycle, freeze pipeline.
- cpu_rdata  out  DATA_W  load data.
- cpu_rvalid  out  1  load data valid, one cycle after the load grant.
- scan_en  in  1  enable for the display scan.
- scan_data  out  DATA_W  scanned word.
- scan_addr  out  ADDR_W  address of scan_data.
- scan_valid  out  1  scan_data/scan_addr valid.
- frame_done  out  1  one-cycle pulse, coincident with scan_valid of the last window word.
- mem_addr  out  ADDR_W  memory address (combinational from grant).
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; synchronous, valid the cycle after address.

Behaviour:
- Reset (in_RST=0, async):
  - scan FSM=IDLE, scan pointer=SCAN_BASE, wait_cnt=0, return tag=NONE.
  - cpu_rvalid, scan_valid, frame_done and mem_we are 0; registered data outputs are 0.
  - Any in-flight read return is discarded.
- Scan FSM:
  - IDLE: no scan request. Moves to RUN when scan_en=1; the pointer restarts at SCAN_BASE.
  - RUN: scan request pending every cycle.
  - On each scan grant the pointer increments. At SCAN_BASE+SCAN_LEN-1 it wraps to SCAN_BASE.
  - At the wrap grant: if scan_en=0, go to IDLE; otherwise stay in RUN.
  - Deasserting scan_en mid-frame finishes the frame; no partial frames.
- Arbitration, per cycle:
  - force = RUN and wait_cnt==MAX_WAIT.
  - Grant the CPU if cpu_req and !force. Otherwise grant the scan if in RUN. Otherwise there is no grant.
  - cpu_stall = cpu_req and grant!=CPU.
- wait_cnt:
  - +1 when in RUN and the scan is not granted.
  - Saturates at MAX_WAIT.
  - Clears on a scan grant or on entry to IDLE.
- Memory drive:
  - CPU grant: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - Scan grant: mem_addr=scan pointer, mem_we=0.
  - No grant: mem_addr=scan pointer, mem_we=0.
- Return path:
  - A registered tag (NONE/CPU/SCAN plus the scan address and a last-word flag) captures the granted read.
  - Next cycle, tag CPU: cpu_rvalid=1, cpu_rdata=mem_rdata.
  - Next cycle, tag SCAN: scan_valid=1, scan_data=mem_rdata, scan_addr=tagged address; frame_done=1 if last-word.
  - Stores produce no return.
  - The valid outputs are single-cycle pulses. cpu_rdata and scan_data hold their last value otherwise.
- Throughput and latency:
  - With no CPU traffic, one scan word per cycle; frame period = SCAN_LEN cycles.
  - Worst-case CPU stall: 1 cycle per MAX_WAIT+1 cycles.
  - Load latency: 1 cycle after grant.
- Simultaneous events:
  - A forced scan and cpu_req in the same cycle: the scan wins and the CPU stalls. The next cycle the CPU wins, because wait_cnt=0.
  - scan_en falling on the wrap grant cycle: the FSM goes to IDLE.

Test Plan:
1. Reset, scan_en=1, cpu_req=0, memory word i = 0x1000+i, SCAN_LEN=64 -> scan_valid from cycle 2 with scan_addr 0..63 and data 0x1000..0x103F, frame_done only on addr 63, then wraps to addr 0; cpu_stall=0.
2. scan_en=0, CPU store 0xDEADBEEF to addr 5, then load addr 5 -> mem_we=1 on the store cycle; cpu_rvalid=1 exactly one cycle after the load with cpu_rdata=0xDEADBEEF; no stalls.
3. scan_en=1, cpu_req held 1 (loads) for 20 cycles, MAX_WAIT=7 -> cpu_stall=1 on cycles 8 and 16; a scan word is returned after each forced grant; no other stalls.
4. Deassert scan_en at scan pointer 10 -> scan continues through addr 63, frame_done pulses, FSM goes to IDLE, no further scan_valid.
5. Assert in_RST low while a load is in flight -> cpu_rvalid stays 0, all outputs 0 immediately; after release, a scan restarts at SCAN_BASE.
6. Forced-scan cycle coincident with a CPU store -> mem_we=0 that cycle and cpu_stall=1; the store is written in the next cycle with its held address/data.
